// File: rtl/connect4_pkg.sv
// Shared Connect Four definitions: board geometry, win encodings and the
// turn sequencer state set.
package connect4_pkg;

  localparam int NUM_COLS  = 7;
  localparam int NUM_ROWS  = 6;
  localparam int MAX_MOVES = NUM_COLS * NUM_ROWS;

  localparam int CURSOR_W = 3;
  localparam int COUNT_W  = 6;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;

  typedef enum logic [2:0] {
    PLAY,
    DROP,
    SETTLE,
    CHECK,
    WON,
    DRAW
  } state_e;

endpackage

// File: rtl/column_cursor.sv
// Wrap-around cursor register with a one-hot column select decode that can
// be blanked once the game has ended.
module column_cursor #(
  parameter int NUM_COLS = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                step_left,
  input  logic                step_right,
  input  logic                blank,
  output logic [2:0]          cursor,
  output logic [NUM_COLS-1:0] column_sel
);
  import connect4_pkg::*;

  localparam logic [CURSOR_W-1:0] HOME = CURSOR_W'(NUM_COLS / 2);
  localparam logic [CURSOR_W-1:0] LAST = CURSOR_W'(NUM_COLS - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor <= HOME;
    end else if (clear) begin
      cursor <= HOME;
    end else if (step_left) begin
      cursor <= (cursor == '0) ? LAST : cursor - 1'b1;
    end else if (step_right) begin
      cursor <= (cursor == LAST) ? '0 : cursor + 1'b1;
    end
  end

  always_comb begin
    column_sel = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      column_sel[c] = !blank && (cursor == CURSOR_W'(c));
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Game-level Connect Four controller: cursor, player turn, move sequencing
// into the column array and latched win/draw outcome.
module turn_sequencer #(
  parameter int NUM_COLS      = connect4_pkg::NUM_COLS,
  parameter int NUM_ROWS      = connect4_pkg::NUM_ROWS,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_drop,
  input  logic                btn_restart,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic [1:0]          win_detect,
  output logic [NUM_COLS-1:0] column_sel,
  output logic                change,
  output logic                player_colour,
  output logic [1:0]          win,
  output logic [2:0]          cursor,
  output logic [5:0]          move_count,
  output logic                rejected,
  output logic                game_over,
  output logic                draw,
  output logic                board_clear
);
  import connect4_pkg::*;

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0]  MOVE_LIMIT  = COUNT_W'(NUM_COLS * NUM_ROWS);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                player_d;
  logic [1:0]          win_d;
  logic [COUNT_W-1:0]  count_d;
  logic                rejected_d;
  logic                step_left, step_right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PLAY;
      settle_q      <= '0;
      player_colour <= 1'b0;
      win           <= WIN_NONE;
      move_count    <= '0;
      rejected      <= 1'b0;
      board_clear   <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      player_colour <= player_d;
      win           <= win_d;
      move_count    <= count_d;
      rejected      <= rejected_d;
      board_clear   <= btn_restart;
    end
  end

  // Restart overrides everything; otherwise buttons only matter in PLAY.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    player_d   = player_colour;
    win_d      = win;
    count_d    = move_count;
    rejected_d = 1'b0;
    step_left  = 1'b0;
    step_right = 1'b0;
    if (btn_restart) begin
      state_d  = PLAY;
      settle_d = '0;
      player_d = 1'b0;
      win_d    = WIN_NONE;
      count_d  = '0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (btn_drop) begin
            if (col_full[cursor]) rejected_d = 1'b1;
            else                  state_d    = DROP;
          end else begin
            step_left  = btn_left & ~btn_right;
            step_right = btn_right & ~btn_left;
          end
        end
        DROP: begin
          state_d  = SETTLE;
          settle_d = '0;
          if (move_count != MOVE_LIMIT) count_d = move_count + 1'b1;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d  = CHECK;
          else                         settle_d = settle_q + 1'b1;
        end
        CHECK: begin
          if (win_detect == WIN_P0 || win_detect == WIN_P1) begin
            win_d   = win_detect;
            state_d = WON;
          end else if (move_count == MOVE_LIMIT) begin
            state_d = DRAW;
          end else begin
            player_d = ~player_colour;
            state_d  = PLAY;
          end
        end
        WON, DRAW: begin
          state_d = state_q;
        end
        default: state_d = PLAY;
      endcase
    end
  end

  assign change    = (state_q == DROP);
  assign game_over = (state_q == WON) || (state_q == DRAW);
  assign draw      = (state_q == DRAW);

  column_cursor #(
    .NUM_COLS(NUM_COLS)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .clear     (btn_restart),
    .step_left (step_left),
    .step_right(step_right),
    .blank     (game_over),
    .cursor    (cursor),
    .column_sel(column_sel)
  );

endmodule

// File: tb/tb_turn_sequencer.sv
// Table-driven bench for turn_sequencer with a scoreboard queue of expected
// output bundles, plus a full-board draw game and an async reset check.
module tb_turn_sequencer;
  import connect4_pkg::*;

  typedef struct packed {
    logic [2:0] cursor;
    logic [6:0] column_sel;
    logic       change;
    logic       rejected;
    logic       player;
    logic [1:0] win;
    logic [5:0] move_count;
    logic       game_over;
    logic       draw;
    logic       board_clear;
  } outs_t;

  typedef struct {
    string      name;
    logic [3:0] btn;
    logic [6:0] col_full;
    logic [1:0] win_detect;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, btn_restart = 1'b0;
  logic [6:0] col_full = '0;
  logic [1:0] win_detect = '0;
  logic [6:0] column_sel;
  logic       change, player_colour, rejected, game_over, draw, board_clear;
  logic [1:0] win;
  logic [2:0] cursor;
  logic [5:0] move_count;

  int    vectors_applied = 0;
  int    miscompares = 0;
  outs_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  turn_sequencer #(
    .NUM_COLS     (7),
    .NUM_ROWS     (6),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_drop     (btn_drop),
    .btn_restart  (btn_restart),
    .col_full     (col_full),
    .win_detect   (win_detect),
    .column_sel   (column_sel),
    .change       (change),
    .player_colour(player_colour),
    .win          (win),
    .cursor       (cursor),
    .move_count   (move_count),
    .rejected     (rejected),
    .game_over    (game_over),
    .draw         (draw),
    .board_clear  (board_clear)
  );

  always #5 clk = ~clk;

  // flags_a = {change, rejected, player}, flags_b = {game_over, draw, board_clear}
  function automatic outs_t e(logic [2:0] cur, logic [2:0] flags_a, logic [1:0] w,
                              logic [5:0] cnt, logic [2:0] flags_b);
    outs_t o;
    o.cursor      = cur;
    o.column_sel  = flags_b[2] ? 7'b0000000 : (7'b0000001 << cur);
    o.change      = flags_a[2];
    o.rejected    = flags_a[1];
    o.player      = flags_a[0];
    o.win         = w;
    o.move_count  = cnt;
    o.game_over   = flags_b[2];
    o.draw        = flags_b[1];
    o.board_clear = flags_b[0];
    return o;
  endfunction

  function automatic vec_t mk(string name, logic [3:0] btn, logic [6:0] cf,
                              logic [1:0] wd, outs_t ex);
    vec_t v;
    v.name = name; v.btn = btn; v.col_full = cf; v.win_detect = wd; v.exp = ex;
    return v;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("cur=%0d sel=%b chg=%b rej=%b pl=%b win=%b cnt=%0d go=%b dr=%b bc=%b",
                     o.cursor, o.column_sel, o.change, o.rejected, o.player, o.win,
                     o.move_count, o.game_over, o.draw, o.board_clear);
  endfunction

  // btn = {restart, left, right, drop}; called at a falling edge
  task automatic applyStimulus(input vec_t v);
    btn_restart = v.btn[3];
    btn_left    = v.btn[2];
    btn_right   = v.btn[1];
    btn_drop    = v.btn[0];
    col_full    = v.col_full;
    win_detect  = v.win_detect;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
  endtask

  task automatic checkOutput();
    outs_t act, ex;
    string nm;
    act.cursor = cursor; act.column_sel = column_sel; act.change = change;
    act.rejected = rejected; act.player = player_colour; act.win = win;
    act.move_count = move_count; act.game_over = game_over; act.draw = draw;
    act.board_clear = board_clear;
    vectors_applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got %s, expected nothing queued", fmt(act));
    end else begin
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act !== ex) begin
        miscompares++;
        $display("[TB] FAIL %s: got %s, expected %s", nm, fmt(act), fmt(ex));
      end
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    vecs.push_back(mk("left1",       4'b0100, 7'h00, 2'b00, e(3'd2, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("left2",       4'b0100, 7'h00, 2'b00, e(3'd1, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("left3",       4'b0100, 7'h00, 2'b00, e(3'd0, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("left_wrap",   4'b0100, 7'h00, 2'b00, e(3'd6, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("left_right",  4'b0110, 7'h00, 2'b00, e(3'd6, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("right_wrap",  4'b0010, 7'h00, 2'b00, e(3'd0, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("right1",      4'b0010, 7'h00, 2'b00, e(3'd1, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("right2",      4'b0010, 7'h00, 2'b00, e(3'd2, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("right3",      4'b0010, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("drop_change", 4'b0001, 7'h00, 2'b00, e(3'd3, 3'b100, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("settle1",     4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("settle_left", 4'b0100, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("check",       4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("toggle_n5",   4'b0000, 7'h00, 2'b00, e(3'd3, 3'b001, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("p1_left1",    4'b0100, 7'h00, 2'b00, e(3'd2, 3'b001, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("p1_left2",    4'b0100, 7'h00, 2'b00, e(3'd1, 3'b001, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("p1_left3",    4'b0100, 7'h00, 2'b00, e(3'd0, 3'b001, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("reject",      4'b0001, 7'h01, 2'b00, e(3'd0, 3'b011, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("reject_end",  4'b0000, 7'h01, 2'b00, e(3'd0, 3'b001, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("drop_prio",   4'b0101, 7'h00, 2'b00, e(3'd0, 3'b101, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("w_settle1",   4'b0000, 7'h00, 2'b00, e(3'd0, 3'b001, 2'b00, 6'd2, 3'b000)));
    vecs.push_back(mk("w_settle2",   4'b0000, 7'h00, 2'b00, e(3'd0, 3'b001, 2'b00, 6'd2, 3'b000)));
    vecs.push_back(mk("w_check",     4'b0000, 7'h00, 2'b00, e(3'd0, 3'b001, 2'b00, 6'd2, 3'b000)));
    vecs.push_back(mk("win_p0",      4'b0000, 7'h00, 2'b01, e(3'd0, 3'b001, 2'b01, 6'd2, 3'b100)));
    vecs.push_back(mk("won_drop",    4'b0001, 7'h00, 2'b00, e(3'd0, 3'b001, 2'b01, 6'd2, 3'b100)));
    vecs.push_back(mk("won_right",   4'b0010, 7'h00, 2'b00, e(3'd0, 3'b001, 2'b01, 6'd2, 3'b100)));
    vecs.push_back(mk("restart_won", 4'b1000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b001)));
    vecs.push_back(mk("clear_end",   4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("drop2",       4'b0001, 7'h00, 2'b00, e(3'd3, 3'b100, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("settle_b",    4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("rst_settle",  4'b1000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b001)));
    vecs.push_back(mk("rst_on_drop", 4'b1001, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b001)));
    vecs.push_back(mk("no_change",   4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("drop3",       4'b0001, 7'h00, 2'b00, e(3'd3, 3'b100, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("rst_in_drop", 4'b1000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b001)));
    vecs.push_back(mk("idle_a",      4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("drop4",       4'b0001, 7'h00, 2'b00, e(3'd3, 3'b100, 2'b00, 6'd0, 3'b000)));
    vecs.push_back(mk("r_settle1",   4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("r_settle2",   4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("r_check",     4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd1, 3'b000)));
    vecs.push_back(mk("reserved_11", 4'b0000, 7'h00, 2'b11, e(3'd3, 3'b001, 2'b00, 6'd1, 3'b000)));

    // Reset state while reset is held low
    repeat (2) @(negedge clk);
    exp_q.push_back(e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000));
    name_q.push_back("reset_state");
    checkOutput();
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

    // Full-board game ending in a draw
    runVec(mk("draw_restart", 4'b1000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b001)));
    for (int m = 0; m < 42; m++) begin
      runVec(mk("draw_drop", 4'b0001, 7'h00, 2'b00,
                e(3'd3, {1'b1, 1'b0, m[0]}, 2'b00, 6'(m), 3'b000)));
      for (int k = 0; k < 3; k++)
        runVec(mk("draw_wait", 4'b0000, 7'h00, 2'b00,
                  e(3'd3, {2'b00, m[0]}, 2'b00, 6'(m + 1), 3'b000)));
      if (m < 41)
        runVec(mk("draw_toggle", 4'b0000, 7'h00, 2'b00,
                  e(3'd3, {2'b00, ~m[0]}, 2'b00, 6'(m + 1), 3'b000)));
      else
        runVec(mk("draw_final", 4'b0000, 7'h00, 2'b00,
                  e(3'd3, 3'b001, 2'b00, 6'd42, 3'b110)));
    end
    runVec(mk("draw_drop_ignored", 4'b0001, 7'h00, 2'b00, e(3'd3, 3'b001, 2'b00, 6'd42, 3'b110)));
    runVec(mk("draw_left_ignored", 4'b0100, 7'h00, 2'b00, e(3'd3, 3'b001, 2'b00, 6'd42, 3'b110)));

    // Asynchronous reset in the middle of DROP
    runVec(mk("async_restart", 4'b1000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b001)));
    runVec(mk("async_left",    4'b0100, 7'h00, 2'b00, e(3'd2, 3'b000, 2'b00, 6'd0, 3'b000)));
    runVec(mk("async_drop",    4'b0001, 7'h00, 2'b00, e(3'd2, 3'b100, 2'b00, 6'd0, 3'b000)));
    v = mk("idle", 4'b0000, 7'h00, 2'b00, e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000));
    btn_drop = 1'b0;
    reset = 1'b0;
    #1;
    exp_q.push_back(e(3'd3, 3'b000, 2'b00, 6'd0, 3'b000));
    name_q.push_back("async_reset_mid_drop");
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    runVec(v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-level controller for the Connect Four board. Owns the cursor column, the current player and the win/draw outcome, and sequences every move into the seven column instances. Turns debounced button pulses into a one-hot column select plus a single-cycle `change` strobe, then waits for the downstream win checker. Sits between the button front-end and the board/column array.

## Interface
Parameters:
- `NUM_COLS`, 7, number of board columns (cursor range 0..NUM_COLS-1)
- `NUM_ROWS`, 6, cells per column; `MAX_MOVES` = NUM_COLS*NUM_ROWS (42)
- `SETTLE_CYCLES`, 2, cycles allowed for the win checker after each `change` (≥1)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `btn_left`, `btn_right`, `btn_drop`, `btn_restart`  in  1 each  single-cycle debounced pulses
- `col_full`  in  NUM_COLS  bit c = top cell of column c occupied
- `win_detect`  in  2  win checker result: 00 none, 01 player 0, 10 player 1, 11 reserved (treated as none)
- `column_sel`  out  NUM_COLS  one-hot column select, drives each column's select input
- `change`  out  1  one-cycle strobe committing a counter in the selected column
- `player_colour`  out  1  player to move (0/1)
- `win`  out  2  latched outcome, broadcast to all columns
- `cursor`  out  3  current cursor column index
- `move_count`  out  6  counters placed this game
- `rejected`  out  1  one-cycle pulse, drop into full column refused
- `game_over`, `draw`  out  1 each  game finished / finished with no winner
- `board_clear`  out  1  one-cycle pulse requesting column clear on restart

## Operation
- States: PLAY, DROP, SETTLE, CHECK, WON, DRAW.
- Reset values: state PLAY, `cursor`=3, `column_sel`=7'b0001000, `player_colour`=0, `win`=00, `move_count`=0, all pulses/flags 0.
- PLAY:
  - `btn_left` moves the cursor down with wrap (0→6); `btn_right` moves it up with wrap (6→0).
  - `btn_left`+`btn_right` together: no move.
  - `btn_drop` has priority over left/right. If `col_full[cursor]`=1, pulse `rejected` and stay in PLAY. Otherwise go to DROP.
- DROP: exactly one cycle. `change`=1, `move_count`+1, then go to SETTLE.
- SETTLE: counts SETTLE_CYCLES, then goes to CHECK. Buttons ignored.
- CHECK: one cycle.
  - `win_detect`∈{01,10}: latch it into `win`, go to WON.
  - Else if `move_count`==MAX_MOVES: go to DRAW.
  - Else toggle `player_colour` and go to PLAY.
- WON/DRAW: `game_over`=1, `draw`=1 only in DRAW. `column_sel`=0. Left/right/drop ignored.
- `btn_restart`, accepted in any state:
  - Next cycle returns all registers to reset values and pulses `board_clear`.
  - Overrides any simultaneous button.
  - Restart in DROP: `change` already issued stands. Restart coincident with entry to DROP: no `change`.
- `column_sel` = one-hot of `cursor` in PLAY/DROP/SETTLE/CHECK, and 0 in WON/DRAW.
- `move_count` saturates at MAX_MOVES and never wraps.

## Timing
- Outputs are registered or decoded from registers only. No input-to-output combinational path.
- `btn_drop` sampled at edge N: `change` high during cycle N+1 only. SETTLE occupies N+2..N+1+SETTLE_CYCLES. CHECK follows at N+2+SETTLE_CYCLES.
- New `player_colour`/`win`/state is visible from cycle N+3+SETTLE_CYCLES. Per-move latency is 3+SETTLE_CYCLES.
- `cursor` updates one cycle after a left/right pulse.
- `rejected` and `board_clear` are high for exactly one cycle, the cycle after the triggering pulse.
- `reset` low mid-move: all outputs take reset values immediately (asynchronous). The in-flight `change` is dropped.

## Structure
- Shared `connect4_pkg`:
  - NUM_COLS, NUM_ROWS, MAX_MOVES
  - WIN_NONE/WIN_P0/WIN_P1 encodings
  - state enum
- Sub-module `column_cursor`: wrap-around cursor register plus one-hot decode to `column_sel`, with a blank input for WON/DRAW.

## Test plan
- Reset, then 4× `btn_left` → cursor 3→2→1→0→6, `column_sel`=7'b1000000.
- Drop at cursor 3 → `change` one cycle at N+1 with `column_sel`=7'b0001000. `player_colour` 0→1 at N+5 (SETTLE_CYCLES=2). `move_count`=1.
- Fill column 0 (`col_full[0]`=1), then drop → `rejected` pulse, no `change`, player unchanged.
- Drop with `win_detect`=01 held through CHECK → `win`=01, `game_over`=1, `column_sel`=0; later drops ignored.
- 42 accepted drops with `win_detect`=00 → `draw`=1, `move_count`=42.
- `btn_restart` during SETTLE → next cycle state PLAY, `board_clear` pulse, cursor 3; `reset` low mid-DROP clears `change` asynchronously.
